// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access size encodings,
// FSM states and the size/alignment legality check.
package mem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // Rejects unaligned halves/words, unsigned stores and undefined encodings.
   function automatic logic size_err(input logic we, input logic [2:0] size,
                                     input logic [1:0] lane);
      logic err;
      case (size)
         SZ_B:    err = 1'b0;
         SZ_BU:   err = we;
         SZ_H:    err = lane[0];
         SZ_HU:   err = we | lane[0];
         SZ_W:    err = |lane;
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-indexed storage built from four byte-wide banks: byte-enabled
// synchronous write, asynchronous word read at the same index.
module dmem_byte_array #(
   parameter int unsigned IDX_W = 15
) (
   input  logic             clk,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);
   localparam int unsigned DEPTH = 2 ** IDX_W;

   for (genvar l = 0; l < 4; l++) begin : g_bank
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (be[l]) mem[idx] <= wdata[8*l +: 8];
      end

      assign rdata[8*l +: 8] = mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// Load/store port responder: one outstanding request, WAIT_CYCLES wait states,
// byte/half/word access with load extension, response over valid/ready.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 17,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_size,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int unsigned IDX_W = ADDR_WIDTH - 2;
   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic                    lat_we;
   logic                    lat_err;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [31:0]             lat_wdata;
   logic [2:0]              lat_size;

   logic                    accept;
   logic                    access;
   logic                    req_err;
   logic                    cur_we;
   logic                    cur_err;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [31:0]             cur_wdata;
   logic [2:0]              cur_size;
   logic [3:0]              be;
   logic [31:0]             wdata_lanes;
   logic [31:0]             word;
   logic [31:0]             load_data;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;

   assign accept  = req_valid && req_ready;
   assign req_err = size_err(req_we, req_size, req_addr[1:0]) ||
                    ((req_addr >> ADDR_WIDTH) != 32'd0);

   // With zero wait states the access happens on the accept edge itself, so the
   // live request is used instead of the not-yet-latched copy.
   always_comb begin
      cur_we    = lat_we;
      cur_err   = lat_err;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_size  = lat_size;
      access    = (state == WAIT) && (cnt == '0);
      if (state == IDLE) begin
         cur_we    = req_we;
         cur_err   = req_err;
         cur_addr  = req_addr[ADDR_WIDTH-1:0];
         cur_wdata = req_wdata;
         cur_size  = req_size;
         access    = accept && (WAIT_CYCLES == 0);
      end
   end

   // Store lane steering; nothing is written on error or while in reset.
   always_comb begin
      be          = 4'b0000;
      wdata_lanes = cur_wdata;
      case (cur_size)
         SZ_B: begin
            be          = 4'b0001 << cur_addr[1:0];
            wdata_lanes = {4{cur_wdata[7:0]}};
         end
         SZ_H: begin
            be          = cur_addr[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{cur_wdata[15:0]}};
         end
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      if (!(access && cur_we && !cur_err) || rst) be = 4'b0000;
   end

   dmem_byte_array #(.IDX_W(IDX_W)) u_array (
      .clk   (clk),
      .be    (be),
      .idx   (cur_addr[ADDR_WIDTH-1:2]),
      .wdata (wdata_lanes),
      .rdata (word)
   );

   // Load lane selection and sign/zero extension.
   always_comb begin
      byte_sel  = 8'(word >> {cur_addr[1:0], 3'b000});
      half_sel  = cur_addr[1] ? word[31:16] : word[15:0];
      load_data = 32'd0;
      case (cur_size)
         SZ_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         SZ_BU:   load_data = {24'd0, byte_sel};
         SZ_H:    load_data = {{16{half_sel[15]}}, half_sel};
         SZ_HU:   load_data = {16'd0, half_sel};
         SZ_W:    load_data = word;
         default: load_data = 32'd0;
      endcase
      if (cur_we || cur_err) load_data = 32'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         cnt        <= '0;
         lat_we     <= 1'b0;
         lat_err    <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= 32'd0;
         lat_size   <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_we    <= req_we;
                  lat_err   <= req_err;
                  lat_addr  <= req_addr[ADDR_WIDTH-1:0];
                  lat_wdata <= req_wdata;
                  lat_size  <= req_size;
                  req_ready <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= load_data;
                     resp_err   <= req_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_W'(WAIT_CYCLES - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= load_data;
                  resp_err   <= lat_err;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= 32'd0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed load/store scenarios plus random traffic
// against a byte-addressed reference model, on WAIT_CYCLES=2 and =0 instances.
module tb_dmem_responder;
   import mem_pkg::*;

   localparam int unsigned AW = 17;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [2];
   logic        resp_ready [2];
   logic        req_ready [2];
   logic        resp_valid [2];
   logic        resp_err [2];
   logic [31:0] resp_rdata [2];
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_size;

   int unsigned waits [2] = '{2, 0};
   int          total = 0;
   int          bad = 0;
   logic [7:0]  mm [longint unsigned];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: byte-addressed memory per instance, rules applied directly.
   function automatic void model(input int s, input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [2:0] sz,
                                 output logic [31:0] rd, output logic er);
      int n;
      bit sgn;
      logic [31:0] v;
      longint unsigned base = longint'(s) << 32;
      n = 0;
      sgn = 0;
      case (sz)
         3'b000: begin n = 1; sgn = 1; end
         3'b100: n = 1;
         3'b001: begin n = 2; sgn = 1; end
         3'b101: n = 2;
         3'b010: n = 4;
         default: n = 0;
      endcase
      if (n == 0) er = 1'b1;
      else er = ((a % n) != 0) || (a >= (32'd1 << AW)) || (we && sz[2]);
      rd = 32'd0;
      if (er) return;
      if (we) begin
         for (int i = 0; i < n; i++) mm[base + a + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(mm[base + a + i]) << (8*i));
         if (sgn && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
         rd = v;
      end
   endfunction

   task automatic txn(input int s, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] sz, input int hold, input bit poke, input string tag,
                      output logic [31:0] rd, output logic er);
      logic [31:0] erd;
      logic        eer;
      int          lat;
      bit          seen;
      model(s, we, a, wd, sz, erd, eer);
      @(negedge clk);
      chk({tag, ".req_ready"}, 32'(req_ready[s]), 32'd1);
      req_we = we; req_addr = a; req_wdata = wd; req_size = sz;
      req_valid[s] = 1'b1;
      @(posedge clk);
      lat = 0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         lat++;
         @(negedge clk);
         req_valid[s] = 1'b0;
         req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom);
         if (resp_valid[s]) begin
            seen = 1;
            break;
         end
         @(posedge clk);
      end
      chk({tag, ".resp_valid"}, 32'(seen), 32'd1);
      chk({tag, ".latency"}, 32'(lat), waits[s] + 1);
      chk({tag, ".rdata"}, resp_rdata[s], erd);
      chk({tag, ".err"}, 32'(resp_err[s]), 32'(eer));
      rd = resp_rdata[s];
      er = resp_err[s];
      for (int h = 0; h < hold; h++) begin
         req_valid[s] = poke;
         req_we = 1'b1; req_addr = 32'h104; req_wdata = 32'h0BADBEEF; req_size = SZ_W;
         @(posedge clk);
         @(negedge clk);
         chk({tag, ".hold_valid"}, 32'(resp_valid[s]), 32'd1);
         chk({tag, ".hold_rdata"}, resp_rdata[s], erd);
         chk({tag, ".hold_err"}, 32'(resp_err[s]), 32'(eer));
         chk({tag, ".hold_ready"}, 32'(req_ready[s]), 32'd0);
      end
      req_valid[s] = 1'b0;
      resp_ready[s] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready[s] = 1'b0;
      chk({tag, ".done_valid"}, 32'(resp_valid[s]), 32'd0);
      chk({tag, ".done_ready"}, 32'(req_ready[s]), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [31:0] a;
      rst = 1'b1;
      req_valid = '{1'b0, 1'b0};
      resp_ready = '{1'b0, 1'b0};
      req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_size = SZ_W;
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst.req_ready", 32'(req_ready[s]), 32'd1);
         chk("rst.resp_valid", 32'(resp_valid[s]), 32'd0);
         chk("rst.resp_rdata", resp_rdata[s], 32'd0);
         chk("rst.resp_err", 32'(resp_err[s]), 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed scenarios on the two-wait-state instance.
      txn(0, 1, 32'h0,     32'h5A5A0001, SZ_W,  0, 0, "sw0",   rd, er);
      txn(0, 1, 32'h100,   32'hDEADBEEF, SZ_W,  0, 0, "sw100", rd, er);
      txn(0, 1, 32'h104,   32'h11112222, SZ_W,  0, 0, "sw104", rd, er);
      txn(0, 0, 32'h100,   32'h0,        SZ_W,  0, 0, "lw",    rd, er);
      chk("lw.const", rd, 32'hDEADBEEF);
      txn(0, 0, 32'h103,   32'h0,        SZ_B,  0, 0, "lb",    rd, er);
      chk("lb.const", rd, 32'hFFFFFFDE);
      txn(0, 0, 32'h103,   32'h0,        SZ_BU, 0, 0, "lbu",   rd, er);
      chk("lbu.const", rd, 32'h000000DE);
      txn(0, 0, 32'h102,   32'h0,        SZ_H,  0, 0, "lh",    rd, er);
      chk("lh.const", rd, 32'hFFFFDEAD);
      txn(0, 0, 32'h100,   32'h0,        SZ_HU, 0, 0, "lhu",   rd, er);
      chk("lhu.const", rd, 32'h0000BEEF);
      txn(0, 1, 32'h101,   32'h12345655, SZ_B,  0, 0, "sb",    rd, er);
      txn(0, 0, 32'h100,   32'h0,        SZ_W,  0, 0, "lw_sb", rd, er);
      chk("lw_sb.const", rd, 32'hDEAD55EF);
      txn(0, 1, 32'h102,   32'h00008001, SZ_H,  0, 0, "sh",    rd, er);
      txn(0, 0, 32'h100,   32'h0,        SZ_W,  0, 0, "lw_sh", rd, er);
      chk("lw_sh.const", rd, 32'h800155EF);
      txn(0, 0, 32'h102,   32'h0,        SZ_W,  0, 0, "lw_mis", rd, er);
      chk("lw_mis.err", 32'(er), 32'd1);
      chk("lw_mis.rdata", rd, 32'd0);
      txn(0, 1, 32'h20000, 32'hFFFFFFFF, SZ_W,  0, 0, "sw_oor", rd, er);
      chk("sw_oor.err", 32'(er), 32'd1);
      txn(0, 0, 32'h0,     32'h0,        SZ_W,  0, 0, "lw0",   rd, er);
      chk("lw0.const", rd, 32'h5A5A0001);
      txn(0, 0, 32'h100,   32'h0,        3'b011, 0, 0, "sz011", rd, er);
      chk("sz011.err", 32'(er), 32'd1);
      txn(0, 1, 32'h100,   32'h0000FFFF, SZ_HU, 0, 0, "shu",   rd, er);
      chk("shu.err", 32'(er), 32'd1);

      // Backpressure with a competing request that must not be accepted.
      txn(0, 0, 32'h100,   32'h0,        SZ_W,  4, 1, "bp",    rd, er);
      txn(0, 0, 32'h104,   32'h0,        SZ_W,  0, 0, "bp_chk", rd, er);
      chk("bp_chk.const", rd, 32'h11112222);

      // Reset during WAIT discards the pending store.
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'hCAFEF00D; req_size = SZ_W;
      req_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstw.req_ready", 32'(req_ready[0]), 32'd1);
      chk("rstw.resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("rstw.resp_rdata", resp_rdata[0], 32'd0);
      chk("rstw.resp_err", 32'(resp_err[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      txn(0, 0, 32'h100,   32'h0,        SZ_W,  0, 0, "lw_rst", rd, er);
      chk("lw_rst.const", rd, 32'h800155EF);

      // Zero-wait-state instance.
      txn(1, 1, 32'h100,   32'hDEADBEEF, SZ_W,  0, 0, "w0.sw", rd, er);
      txn(1, 0, 32'h101,   32'h0,        SZ_B,  2, 0, "w0.lb", rd, er);
      chk("w0.lb.const", rd, 32'hFFFFFFBE);
      txn(1, 0, 32'h101,   32'h0,        SZ_H,  0, 0, "w0.lh", rd, er);
      chk("w0.lh.err", 32'(er), 32'd1);

      // Random traffic on both instances over a small pre-initialised window.
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < 16; w++)
            txn(s, 1, 32'h200 + 32'(4*w), $urandom, SZ_W, 0, 0, "init", rd, er);
         for (int k = 0; k < 40; k++) begin
            a = 32'h200 + ($urandom % 64);
            if ($urandom_range(9) == 0) a = 32'h20000 + ($urandom % 64);
            txn(s, 1'($urandom), a, $urandom, 3'($urandom), int'($urandom_range(2)), 0,
                "rand", rd, er);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
